systolic_skew_feeder: RTL
=========================

Name: systolic_skew_feeder

Overview:
Parametrised successor to the separate A/B zero-padding feeders. The block captures an N x N matrix row by row from the shared bus, where N is selected at run time (1..MAX_DIM). It then streams that matrix into one edge of the systolic array as a diagonally skewed, zero-padded vector sequence. A mode input selects row skew (A operand, west edge) or column skew (B operand, north edge), so one module serves both operands and is driven through a start/busy/done handshake.

Parameters:
DATA_WIDTH, 32, element width in bits
MAX_DIM, 4, maximum matrix dimension and number of output lanes
DIM_W, $clog2(MAX_DIM), width of dim_m1 (localparam)
CNT_W, $clog2(3*MAX_DIM), width of the stream counter (localparam)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
write_enable  input  1  capture bus as the next matrix row
bus  input  MAX_DIM*DATA_WIDTH  row data; element j at bits [DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j]
dim_m1  input  DIM_W  N-1; sampled on the first write of a load
transpose  input  1  0 = row skew (A), 1 = column skew (B); sampled with start
start  input  1  begin streaming; accepted only in FULL
busy  output  1  high in LOAD, FULL and STREAM (and DRAIN)
full  output  1  high in FULL
vector  output  MAX_DIM*DATA_WIDTH  registered skewed lane data
vector_valid  output  1  high on every cycle that vector carries stream data
done  output  1  one-cycle pulse when the stream completes

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; row_cnt=0, stream_cnt=0; matrix buffer cleared to 0.
  - vector=0, vector_valid=0, done=0, busy=0, full=0.
  - Reset mid-LOAD or mid-STREAM aborts immediately; no done pulse.
- States and transitions:
  - IDLE: on write_enable, latch N=dim_m1+1, store bus in row 0, row_cnt=1, go to LOAD (N=1 goes straight to FULL).
  - LOAD: on each write_enable, store bus in row[row_cnt] and increment; after the N-th row go to FULL. Cycles without write_enable hold state (gaps allowed).
  - FULL: start=1 latches transpose, sets stream_cnt=0, goes to STREAM. write_enable in FULL is ignored.
  - STREAM: runs for exactly 2N-1 cycles, t=0..2N-2, then goes to IDLE and pulses done for one cycle.
- Ignored inputs: start outside FULL; write_enable in STREAM or DRAIN. Neither changes the buffer or the state.
- Simultaneous start and write_enable in FULL: start wins and the write is dropped.
- Output timing: vector is registered. Stream cycle t appears on vector the clock after it is computed, so the first valid vector follows the edge that samples start by one cycle. vector_valid is high for the 2N-1 stream cycles.
- Lane content, for lane i at stream cycle t, with k=t-i:
  - transpose=0: vector lane i = M[i][k] if i<N and 0<=k<N, else 0.
  - transpose=1: vector lane i = M[k][i] under the same conditions, else 0.
- Lanes i>=N are always 0. vector=0 whenever vector_valid=0.
- done:
  - Asserts in the cycle after the last valid vector, with vector_valid=0 and busy=0.
  - The block then accepts a new load on that same cycle.
- Buffer contents persist after done. A new load overwrites rows 0..N-1 and zeroes rows N..MAX_DIM-1.

Optional Feature:
SKEW_FEEDER_DRAIN_EN
- Defined: after STREAM the block enters DRAIN for N extra cycles, driving vector=0 with vector_valid=1 so array partial sums flush. done then pulses after 3N-1 valid cycles, and busy stays high through DRAIN.
- Undefined: there is no DRAIN state, and done follows STREAM directly.

Test Plan:
- N=4, transpose=0, rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, then start -> t0 lanes=(1,0,0,0); t1=(2,5,0,0); t3=(4,7,10,13); t6=(0,0,0,16); 7 valid cycles; done on the 8th.
- Same matrix, transpose=1 -> t1=(5,2,0,0); t3=(13,10,7,4); t6=(0,0,0,16).
- N=2 (dim_m1=1) loaded with full 4-wide rows {1,2,x,x},{5,6,x,x}, transpose=0 -> t0=(1,0,0,0); t1=(2,5,0,0); t2=(0,6,0,0); lanes 2-3 always 0; done after 3 valid cycles.
- N=1 with a single write of 7 -> FULL immediately; start yields one cycle (7,0,0,0) then done.
- Handshake edge cases:
  - start in IDLE or LOAD has no effect.
  - write_enable during STREAM leaves the buffer unchanged; a repeat stream reproduces the same output.
  - start and write_enable together in FULL -> stream begins with the original data.
- reset low at t=3 of an N=4 stream:
  - Same cycle: vector=0, vector_valid=0, busy=0, no done pulse.
  - Afterwards: a fresh load and stream behaves normally.
  - With SKEW_FEEDER_DRAIN_EN defined: an N=4 stream gives 4 extra zero-valid cycles and done after 11 valid cycles.

Source files
------------

// File: rtl/systolic_skew_feeder.sv
// Captures an N x N matrix row by row and streams it as diagonally skewed, zero-padded vectors.
// Defining SKEW_FEEDER_DRAIN_EN appends N zero-valued flush cycles after the stream.
module systolic_skew_feeder #(
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_DIM    = 4,
    localparam int DIM_W      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
    localparam int CNT_W      = $clog2(3 * MAX_DIM)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_enable,
    input  logic [MAX_DIM*DATA_WIDTH-1:0] bus,
    input  logic [DIM_W-1:0]              dim_m1,
    input  logic                          transpose,
    input  logic                          start,
    output logic                          busy,
    output logic                          full,
    output logic [MAX_DIM*DATA_WIDTH-1:0] vector,
    output logic                          vector_valid,
    output logic                          done
);

    // state  | meaning
    // IDLE   | waiting for the first row of a load
    // LOAD   | capturing rows 1..N-1
    // FULL   | matrix held, waiting for start
    // STREAM | emitting the 2N-1 skewed vectors
    // DRAIN  | emitting N zero vectors so array partial sums flush
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FULL,
`ifdef SKEW_FEEDER_DRAIN_EN
        S_STREAM,
        S_DRAIN
`else
        S_STREAM
`endif
    } state_e;

    state_e                          state_q;
    logic [DIM_W-1:0]                n_m1_q;
    logic [DIM_W-1:0]                row_cnt_q;
    logic [CNT_W-1:0]                stream_cnt_q;
    logic                            transpose_q;
    logic [MAX_DIM*DATA_WIDTH-1:0]   mat_q [MAX_DIM];
    logic [MAX_DIM*DATA_WIDTH-1:0]   vector_q;
    logic [MAX_DIM*DATA_WIDTH-1:0]   lanes_d;
    logic                            valid_q;
    logic                            done_q;

    // Lane i carries element (i, t-i), so a lane/column pair is selected when i + j == t.
    always_comb begin
        lanes_d = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            for (int j = 0; j < MAX_DIM; j++) begin
                if (i <= int'(n_m1_q) && j <= int'(n_m1_q) && int'(stream_cnt_q) == i + j) begin
                    lanes_d[DATA_WIDTH*i +: DATA_WIDTH] = transpose_q
                        ? mat_q[j][DATA_WIDTH*i +: DATA_WIDTH]
                        : mat_q[i][DATA_WIDTH*j +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            n_m1_q       <= '0;
            row_cnt_q    <= '0;
            stream_cnt_q <= '0;
            transpose_q  <= 1'b0;
            vector_q     <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            for (int r = 0; r < MAX_DIM; r++) mat_q[r] <= '0;
        end else begin
            vector_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (write_enable) begin
                        n_m1_q <= dim_m1;
                        for (int r = 0; r < MAX_DIM; r++) begin
                            if (r == 0) mat_q[r] <= bus;
                            else if (r > int'(dim_m1)) mat_q[r] <= '0;
                        end
                        if (dim_m1 == '0) begin
                            row_cnt_q <= '0;
                            state_q   <= S_FULL;
                        end else begin
                            row_cnt_q <= DIM_W'(1);
                            state_q   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (write_enable) begin
                        mat_q[row_cnt_q] <= bus;
                        if (row_cnt_q == n_m1_q) begin
                            row_cnt_q <= '0;
                            state_q   <= S_FULL;
                        end else begin
                            row_cnt_q <= row_cnt_q + DIM_W'(1);
                        end
                    end
                end
                S_FULL: begin
                    if (start) begin
                        transpose_q  <= transpose;
                        stream_cnt_q <= '0;
                        state_q      <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    vector_q <= lanes_d;
`ifdef SKEW_FEEDER_DRAIN_EN
                    valid_q      <= 1'b1;
                    stream_cnt_q <= stream_cnt_q + CNT_W'(1);
                    if (int'(stream_cnt_q) == 2 * int'(n_m1_q)) state_q <= S_DRAIN;
`else
                    if (int'(stream_cnt_q) == 2 * int'(n_m1_q) + 1) begin
                        done_q       <= 1'b1;
                        stream_cnt_q <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        valid_q      <= 1'b1;
                        stream_cnt_q <= stream_cnt_q + CNT_W'(1);
                    end
`endif
                end
`ifdef SKEW_FEEDER_DRAIN_EN
                S_DRAIN: begin
                    if (int'(stream_cnt_q) == 3 * int'(n_m1_q) + 2) begin
                        done_q       <= 1'b1;
                        stream_cnt_q <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        valid_q      <= 1'b1;
                        stream_cnt_q <= stream_cnt_q + CNT_W'(1);
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign full         = (state_q == S_FULL);
    assign vector       = vector_q;
    assign vector_valid = valid_q;
    assign done         = done_q;

endmodule
